dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-ported `DataMemory`. It sits between the processor's load/store path (core port) and a program/debug loader port (ldr port). It serialises their requests with round-robin priority and drives `mem_read`/`mem_write` for exactly one cycle per access. It also waits out the memory's read latency and returns read data with a one-cycle valid pulse.

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of a single-ported data memory.
// Issues one-cycle mem_read/mem_write strobes, waits out RD_LAT, and returns read data to the owning port.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {PORT_CORE, PORT_LDR} port_t;

  state_t            state_q, state_d;
  port_t             owner_q, owner_d, prio_q, prio_d, sel;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, core_rdata_d, ldr_rdata_d;
  logic              mem_read_d, mem_write_d, busy_d;
  logic              core_gnt_d, ldr_gnt_d, core_rvalid_d, ldr_rvalid_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    prio_d        = prio_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    sel           = PORT_CORE;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    core_rdata_d  = core_rdata;
    ldr_rdata_d   = ldr_rdata;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    core_gnt_d    = 1'b0;
    ldr_gnt_d     = 1'b0;
    core_rvalid_d = 1'b0;
    ldr_rvalid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (core_req || ldr_req) begin
          if (core_req && ldr_req) sel = prio_q;
          else if (ldr_req)        sel = PORT_LDR;
          owner_d = sel;
          state_d = ISSUE;
          // Outputs are registered, so the ISSUE-cycle strobes are prepared here.
          if (sel == PORT_LDR) begin
            we_d        = ldr_we;
            mem_addr_d  = ldr_addr;
            mem_wdata_d = ldr_wdata;
            ldr_gnt_d   = 1'b1;
          end else begin
            we_d        = core_we;
            mem_addr_d  = core_addr;
            mem_wdata_d = core_wdata;
            core_gnt_d  = 1'b1;
          end
          mem_write_d = we_d;
          mem_read_d  = !we_d;
        end
      end
      ISSUE: begin
        prio_d = (owner_q == PORT_CORE) ? PORT_LDR : PORT_CORE;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == PORT_LDR) begin
            ldr_rdata_d  = mem_rdata;
            ldr_rvalid_d = 1'b1;
          end else begin
            core_rdata_d  = mem_rdata;
            core_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      // NOTE: the data registers are reset too, because their reset value is visible on the ports.
      state_q     <= IDLE;
      owner_q     <= PORT_CORE;
      prio_q      <= PORT_CORE;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      core_rdata  <= '0;
      ldr_rdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      core_gnt    <= 1'b0;
      ldr_gnt     <= 1'b0;
      core_rvalid <= 1'b0;
      ldr_rvalid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      core_rdata  <= core_rdata_d;
      ldr_rdata   <= ldr_rdata_d;
      mem_read    <= mem_read_d;
      mem_write   <= mem_write_d;
      core_gnt    <= core_gnt_d;
      ldr_gnt     <= ldr_gnt_d;
      core_rvalid <= core_rvalid_d;
      ldr_rvalid  <= ldr_rvalid_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: instance a uses RD_LAT=1 with a memory model,
// instance b uses RD_LAT=3 with a scripted mem_rdata sequence.
module tb_dmem_arbiter;

  typedef struct {
    bit          resp;
    bit          port;   // 0 = core, 1 = ldr
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] other;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit both_hi = 1'b0;
  bit stray = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];

  // Instance a
  logic        rst_a, core_req_a, core_we_a, ldr_req_a, ldr_we_a;
  logic [31:0] core_addr_a, core_wdata_a, ldr_addr_a, ldr_wdata_a;
  logic        core_gnt_a, core_rvalid_a, ldr_gnt_a, ldr_rvalid_a;
  logic [31:0] core_rdata_a, ldr_rdata_a;
  logic        mem_read_a, mem_write_a, busy_a;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;

  // Instance b
  logic        rst_b, core_req_b, core_we_b, ldr_req_b, ldr_we_b;
  logic [31:0] core_addr_b, core_wdata_b, ldr_addr_b, ldr_wdata_b;
  logic        core_gnt_b, core_rvalid_b, ldr_gnt_b, ldr_rvalid_b;
  logic [31:0] core_rdata_b, ldr_rdata_b;
  logic        mem_read_b, mem_write_b, busy_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst_a),
    .core_req(core_req_a), .core_we(core_we_a), .core_addr(core_addr_a), .core_wdata(core_wdata_a),
    .core_gnt(core_gnt_a), .core_rvalid(core_rvalid_a), .core_rdata(core_rdata_a),
    .ldr_req(ldr_req_a), .ldr_we(ldr_we_a), .ldr_addr(ldr_addr_a), .ldr_wdata(ldr_wdata_a),
    .ldr_gnt(ldr_gnt_a), .ldr_rvalid(ldr_rvalid_a), .ldr_rdata(ldr_rdata_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .core_req(core_req_b), .core_we(core_we_b), .core_addr(core_addr_b), .core_wdata(core_wdata_b),
    .core_gnt(core_gnt_b), .core_rvalid(core_rvalid_b), .core_rdata(core_rdata_b),
    .ldr_req(ldr_req_b), .ldr_we(ldr_we_b), .ldr_addr(ldr_addr_b), .ldr_wdata(ldr_wdata_b),
    .ldr_gnt(ldr_gnt_b), .ldr_rvalid(ldr_rvalid_b), .ldr_rdata(ldr_rdata_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  // One-cycle-latency memory behind instance a; unwritten words read as {C0FFEE, addr[7:0]}.
  logic [31:0] mem [256];
  bit          written [256];
  always @(posedge clk) begin
    if (mem_write_a) begin
      mem[mem_addr_a[7:0]]     <= mem_wdata_a;
      written[mem_addr_a[7:0]] <= 1'b1;
    end
    if (mem_read_a)
      mem_rdata_a <= written[mem_addr_a[7:0]] ? mem[mem_addr_a[7:0]] : {24'hC0FFEE, mem_addr_a[7:0]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void push_gnt(input int d, input bit port, input bit we,
                                   input logic [31:0] addr, input logic [31:0] wdata, input int c);
    exp_t e;
    e = '{resp: 1'b0, port: port, we: we, addr: addr, data: wdata, other: 32'h0, cyc: c};
    if (d == 0) q_a.push_back(e); else q_b.push_back(e);
  endfunction

  function automatic void push_resp(input int d, input bit port, input logic [31:0] data,
                                    input logic [31:0] other, input int c);
    exp_t e;
    e = '{resp: 1'b1, port: port, we: 1'b0, addr: 32'h0, data: data, other: other, cyc: c};
    if (d == 0) q_a.push_back(e); else q_b.push_back(e);
  endfunction

  task automatic mon(input int d, input logic cg, input logic lg, input logic cv, input logic lv,
                     input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] mwd,
                     input logic [31:0] crd, input logic [31:0] lrd);
    exp_t e;
    bit   have;
    if (mr && mw) both_hi = 1'b1;
    if ((mr || mw) && !(cg || lg)) stray = 1'b1;
    if (cg || lg || cv || lv) begin
      have = (d == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
      if (!have) begin
        check($sformatf("unexpected_event_dut%0d", d), 32'({cg, lg, cv, lv}), 32'h0);
      end else begin
        if (d == 0) e = q_a.pop_front(); else e = q_b.pop_front();
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.resp) begin
          check("gnt_lines", 32'({cg, lg, cv, lv}), e.port ? 32'h4 : 32'h8);
          check("mem_strobes", 32'({mr, mw}), e.we ? 32'h1 : 32'h2);
          check("mem_addr", ma, e.addr);
          if (e.we) check("mem_wdata", mwd, e.data);
        end else begin
          check("rvalid_lines", 32'({cg, lg, cv, lv}), e.port ? 32'h1 : 32'h2);
          check("owner_rdata", e.port ? lrd : crd, e.data);
          check("other_rdata", e.port ? crd : lrd, e.other);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, core_gnt_a, ldr_gnt_a, core_rvalid_a, ldr_rvalid_a, mem_read_a, mem_write_a,
        mem_addr_a, mem_wdata_a, core_rdata_a, ldr_rdata_a);
    mon(1, core_gnt_b, ldr_gnt_b, core_rvalid_b, ldr_rvalid_b, mem_read_b, mem_write_b,
        mem_addr_b, mem_wdata_b, core_rdata_b, ldr_rdata_b);
  end

  task automatic wait_gnt_a(input bit port);
    int   n = 0;
    logic got;
    do begin
      @(negedge clk);
      n++;
      got = port ? ldr_gnt_a : core_gnt_a;
    end while (!got && n < 40);
    if (!got) check("gnt_timeout", 32'(got), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic set_port_a(input bit port, input bit req, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      ldr_req_a = req; ldr_we_a = we; ldr_addr_a = addr; ldr_wdata_a = wdata;
    end else begin
      core_req_a = req; core_we_a = we; core_addr_a = addr; core_wdata_a = wdata;
    end
  endtask

  // Single access: hold the request until granted, then release it.
  task automatic access_a(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    set_port_a(port, 1'b1, we, addr, wdata);
    wait_gnt_a(port);
    if (port) ldr_req_a = 1'b0; else core_req_a = 1'b0;
  endtask

  // Back-to-back reads: a new request is posted right after each grant.
  task automatic port_seq_a(input bit port, input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      set_port_a(port, 1'b1, 1'b0, base + 32'(4 * k), 32'h0);
      wait_gnt_a(port);
    end
    if (port) ldr_req_a = 1'b0; else core_req_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_a && n < 40);
    if (busy_a) check("idle_timeout", 32'(busy_a), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          t;
    logic [31:0] a, d, rd_c, rd_l;
    bit          p;

    rst_a = 1'b0; rst_b = 1'b0;
    core_req_a = 1'b1; core_we_a = 1'b0; core_addr_a = 32'h40; core_wdata_a = '0;
    ldr_req_a  = 1'b1; ldr_we_a  = 1'b0; ldr_addr_a  = 32'h80; ldr_wdata_a  = '0;
    core_req_b = 1'b0; core_we_b = 1'b0; core_addr_b = '0; core_wdata_b = '0;
    ldr_req_b  = 1'b0; ldr_we_b  = 1'b0; ldr_addr_b  = '0; ldr_wdata_b  = '0;
    mem_rdata_b = '0;

    // Reset held with both ports requesting: nothing may move.
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ctrl_outputs", 32'({core_gnt_a, ldr_gnt_a, core_rvalid_a, ldr_rvalid_a,
                                     mem_read_a, mem_write_a, busy_a}), 32'h0);
      @(posedge clk); #1;
    end
    check("rst_mem_addr", mem_addr_a, 32'h0);
    check("rst_rdata", core_rdata_a | ldr_rdata_a, 32'h0);

    // Release: core wins first, ldr follows once the core read completes.
    t = cyc;
    rst_a = 1'b1; rst_b = 1'b1;
    push_gnt (0, 1'b0, 1'b0, 32'h40, 32'h0, t + 1);
    push_resp(0, 1'b0, 32'hC0FFEE40, 32'h0, t + 3);
    push_gnt (0, 1'b1, 1'b0, 32'h80, 32'h0, t + 5);
    push_resp(0, 1'b1, 32'hC0FFEE80, 32'hC0FFEE40, t + 7);
    fork
      port_seq_a(1'b0, 1, 32'h40);
      port_seq_a(1'b1, 1, 32'h80);
    join
    wait_idle_a();

    // Core write then read-back of 0x10.
    t = cyc;
    push_gnt(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, t + 1);
    access_a(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    t = cyc;
    push_gnt (0, 1'b0, 1'b0, 32'h10, 32'h0, t + 1);
    push_resp(0, 1'b0, 32'hDEADBEEF, 32'hC0FFEE80, t + 3);
    access_a(1'b0, 1'b0, 32'h10, 32'h0);
    wait_idle_a();

    // Contention after a reset pulse: six reads, strictly alternating from core.
    rst_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    t = cyc;
    rd_c = '0; rd_l = '0;
    for (int k = 0; k < 6; k++) begin
      p = k[0];
      a = (p ? 32'h80 : 32'h40) + 32'(4 * (k / 2));
      d = {24'hC0FFEE, a[7:0]};
      push_gnt (0, p, 1'b0, a, 32'h0, t + 4 * k + 1);
      push_resp(0, p, d, p ? rd_c : rd_l, t + 4 * k + 3);
      if (p) rd_l = d; else rd_c = d;
    end
    fork
      port_seq_a(1'b0, 3, 32'h40);
      port_seq_a(1'b1, 3, 32'h80);
    join
    wait_idle_a();

    // Reset while in WAIT: the read is dropped and no rvalid appears.
    t = cyc;
    push_gnt(0, 1'b0, 1'b0, 32'h50, 32'h0, t + 1);
    access_a(1'b0, 1'b0, 32'h50, 32'h0);
    rst_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy_a), 32'h0);
    check("midrst_core_rdata", core_rdata_a, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    t = cyc;
    push_gnt (0, 1'b0, 1'b0, 32'h54, 32'h0, t + 1);
    push_resp(0, 1'b0, 32'hC0FFEE54, 32'h0, t + 3);
    access_a(1'b0, 1'b0, 32'h54, 32'h0);
    wait_idle_a();

    // Address change in the ISSUE cycle is ignored; the write lands at 0x20.
    t = cyc;
    push_gnt(0, 1'b0, 1'b1, 32'h20, 32'h11112222, t + 1);
    set_port_a(1'b0, 1'b1, 1'b1, 32'h20, 32'h11112222);
    @(posedge clk); #1;
    core_addr_a = 32'h30;
    @(posedge clk); #1;
    core_req_a = 1'b0;
    t = cyc;
    push_gnt (0, 1'b0, 1'b0, 32'h20, 32'h0, t + 1);
    push_resp(0, 1'b0, 32'h11112222, 32'h0, t + 3);
    access_a(1'b0, 1'b0, 32'h20, 32'h0);
    wait_idle_a();

    // RD_LAT=3: data present at ISSUE+3 is the one captured.
    t = cyc;
    push_gnt (1, 1'b1, 1'b0, 32'h99, 32'h0, t + 1);
    push_resp(1, 1'b1, 32'hD, 32'h0, t + 5);
    ldr_req_b = 1'b1; ldr_addr_b = 32'h99;
    @(posedge clk); #1; mem_rdata_b = 32'hA;
    @(posedge clk); #1; mem_rdata_b = 32'hB; ldr_req_b = 1'b0;
    @(posedge clk); #1; mem_rdata_b = 32'hC;
    @(posedge clk); #1; mem_rdata_b = 32'hD;
    @(posedge clk); #1; mem_rdata_b = 32'hE;
    repeat (4) @(posedge clk);

    @(negedge clk);
    check("queue_a_drained", 32'(q_a.size()), 32'h0);
    check("queue_b_drained", 32'(q_b.size()), 32'h0);
    check("read_write_overlap", 32'(both_hi), 32'h0);
    check("strobe_outside_issue", 32'(stray), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
